// File: rtl/aes_pkg.sv
// Shared AES types, round constants and byte-level GF(2^8) helpers.
// The S-box is computed from the field inverse plus the affine map.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam logic [7:0] RCON [11] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam int KEY_BITS_LEGAL [3] = '{128, 192, 256};

  function automatic bit key_bits_legal(int kb);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3; k++)
      if (kb == KEY_BITS_LEGAL[k]) ok = 1'b1;
    return ok;
  endfunction

  function automatic int nr_of(int kb);
    return kb / 32 + 6;
  endfunction

  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] sbox(logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: byte-wise S-box over a 32-bit word, purely combinational.
// Shared with the cipher SubBytes stage.
module aes_subword
  import aes_pkg::*;
(
  input  word_t w_i,
  output word_t w_o
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign w_o[8*g +: 8] = sbox(w_i[8*g +: 8]);
  end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES key schedule: one word per clock into a register file,
// served through a registered round-key read port.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                keys_valid,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = 4 * (NR + 1);
  localparam int CW = $clog2(NW + 1);

  if (!key_bits_legal(KEY_BITS)) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    mod_q;
  logic [3:0]    rc_q;
  logic          busy_q;
  logic          valid_q;
  block_t        rd_key_q;
  word_t         w_q [NW];

  logic          accept;
  logic [5:0]    rb;
  word_t         prev_w;
  word_t         far_w;
  word_t         sub_in;
  word_t         sub_out;
  word_t         temp;
  word_t         new_w;

  assign accept = start && (state_q != EXPAND);
  assign rb     = {rd_round, 2'b00};
  assign prev_w = w_q[cnt_q - CW'(1)];
  assign far_w  = w_q[cnt_q - CW'(NK)];
  assign sub_in = (mod_q == 3'd0) ? rot_word(prev_w) : prev_w;

  aes_subword u_subword (
    .w_i (sub_in),
    .w_o (sub_out)
  );

  always_comb begin
    temp = prev_w;
    if (mod_q == 3'd0)
      temp = sub_out ^ {RCON[rc_q], 24'h0};
    else if (NK == 8 && mod_q == 3'd4)
      temp = sub_out;
    new_w = far_w ^ temp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mod_q    <= '0;
      rc_q     <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      rd_key_q <= '0;
    end else begin
      if (rd_round <= 4'(NR))
        rd_key_q <= {w_q[{rd_round, 2'b00}], w_q[{rd_round, 2'b01}],
                     w_q[{rd_round, 2'b10}], w_q[{rd_round, 2'b11}]};
      else
        rd_key_q <= '0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= EXPAND;
            cnt_q   <= CW'(NK);
            mod_q   <= '0;
            rc_q    <= 4'd1;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        EXPAND: begin
          cnt_q <= cnt_q + CW'(1);
          mod_q <= (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rc_q <= rc_q + 4'd1;
          if (cnt_q == CW'(NW - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage only; old words are simply overwritten by the next run
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < NK; k++)
          w_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
      end else if (state_q == EXPAND) begin
        w_q[cnt_q] <= new_w;
      end
    end
  end

  assign busy       = busy_q;
  assign keys_valid = valid_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed checks of the AES-128/192/256 key expander against FIPS-197 vectors.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_aes_key_expander;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R2_128  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   rd_round;
  logic         s128, s192, s256;
  logic [127:0] k128;
  logic [191:0] k192;
  logic [255:0] k256;
  logic         b128, b192, b256;
  logic         v128, v192, v256;
  logic [127:0] q128, q192, q256;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_key_expander #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .start(s128), .key_in(k128),
    .busy(b128), .keys_valid(v128), .rd_round(rd_round), .rd_key(q128)
  );
  aes_key_expander #(.KEY_BITS(192)) u192 (
    .clk(clk), .rst(rst), .start(s192), .key_in(k192),
    .busy(b192), .keys_valid(v192), .rd_round(rd_round), .rd_key(q192)
  );
  aes_key_expander #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .start(s256), .key_in(k256),
    .busy(b256), .keys_valid(v256), .rd_round(rd_round), .rd_key(q256)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] r);
    rd_round = r;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s128 = 0; s192 = 0; s256 = 0;
    k128 = '0; k192 = '0; k256 = '0;
    rd_round = 4'd0;
    step(); step();
    rst = 1'b0;
    n_chk++;
    if ({b128, v128, b192, v192, b256, v256} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000000",
               {b128, v128, b192, v192, b256, v256});
    end
    n_chk++;
    if ({q128, q192, q256} !== '0) begin
      n_fail++;
      $display("FAIL reset_rdkey got %h %h %h want 0", q128, q192, q256);
    end
  endtask

  task automatic test_aes128();
    int n;
    bit busy_ok;
    k128 = K128;
    s128 = 1'b1;
    step();
    s128 = 1'b0;
    n = 1;
    busy_ok = 1;
    while (!v128 && n < 100) begin
      if (!b128) busy_ok = 0;
      step();
      n++;
    end
    n_chk++;
    if (n !== 41) begin
      n_fail++;
      $display("FAIL a128_done_cycle got T+%0d want T+41", n);
    end
    n_chk++;
    if (!busy_ok || b128 !== 1'b0) begin
      n_fail++;
      $display("FAIL a128_busy got ok=%0d busy_end=%b want ok=1 busy_end=0",
               busy_ok, b128);
    end
    rd(4'd1);
    n_chk++;
    if (q128 !== R1_128) begin
      n_fail++;
      $display("FAIL a128_round1 got %h want %h", q128, R1_128);
    end
    rd(4'd10);
    n_chk++;
    if (q128 !== R10_128) begin
      n_fail++;
      $display("FAIL a128_round10 got %h want %h", q128, R10_128);
    end
    rd(4'd0);
    n_chk++;
    if (q128 !== K128) begin
      n_fail++;
      $display("FAIL a128_round0 got %h want %h", q128, K128);
    end
    rd(4'd15);
    n_chk++;
    if (q128 !== 128'h0) begin
      n_fail++;
      $display("FAIL a128_round15 got %h want 0", q128);
    end
    rd(4'd11);
    n_chk++;
    if (q128 !== 128'h0) begin
      n_fail++;
      $display("FAIL a128_round11 got %h want 0", q128);
    end
  endtask

  task automatic test_aes192();
    int n;
    k192 = K192;
    s192 = 1'b1;
    step();
    s192 = 1'b0;
    n = 1;
    while (!v192 && n < 100) begin
      step();
      n++;
    end
    n_chk++;
    if (n !== 47) begin
      n_fail++;
      $display("FAIL a192_done_cycle got T+%0d want T+47", n);
    end
    rd(4'd12);
    n_chk++;
    if (q192 !== R12_192) begin
      n_fail++;
      $display("FAIL a192_round12 got %h want %h", q192, R12_192);
    end
    rd(4'd0);
    n_chk++;
    if (q192 !== K192[191 -: 128]) begin
      n_fail++;
      $display("FAIL a192_round0 got %h want %h", q192, K192[191 -: 128]);
    end
  endtask

  task automatic test_aes256();
    int n;
    k256 = K256;
    s256 = 1'b1;
    step();
    s256 = 1'b0;
    n = 1;
    while (!v256 && n < 100) begin
      step();
      n++;
    end
    n_chk++;
    if (n !== 53) begin
      n_fail++;
      $display("FAIL a256_done_cycle got T+%0d want T+53", n);
    end
    rd(4'd14);
    n_chk++;
    if (q256 !== R14_256) begin
      n_fail++;
      $display("FAIL a256_round14 got %h want %h", q256, R14_256);
    end
    rd(4'd1);
    n_chk++;
    if (q256 !== K256[127:0]) begin
      n_fail++;
      $display("FAIL a256_round1 got %h want %h", q256, K256[127:0]);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    k128 = K128;
    s128 = 1'b1;
    step();
    s128 = 1'b0;
    n = 1;
    while (!v128 && n < 100) begin
      if (n == 5) begin
        s128 = 1'b1;
        k128 = '0;
      end else begin
        s128 = 1'b0;
      end
      step();
      n++;
    end
    s128 = 1'b0;
    n_chk++;
    if (n !== 41) begin
      n_fail++;
      $display("FAIL ignore_done_cycle got T+%0d want T+41", n);
    end
    rd(4'd10);
    n_chk++;
    if (q128 !== R10_128) begin
      n_fail++;
      $display("FAIL ignore_round10 got %h want %h", q128, R10_128);
    end
    rd(4'd0);
    n_chk++;
    if (q128 !== K128) begin
      n_fail++;
      $display("FAIL ignore_round0 got %h want %h", q128, K128);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    k128 = K128;
    s128 = 1'b1;
    step();
    s128 = 1'b0;
    for (int c = 1; c < 20; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if ({b128, v128} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_flags got busy=%b valid=%b want 0 0", b128, v128);
    end
    s128 = 1'b1;
    step();
    s128 = 1'b0;
    n = 1;
    while (!v128 && n < 100) begin
      step();
      n++;
    end
    n_chk++;
    if (n !== 41) begin
      n_fail++;
      $display("FAIL midrst_done_cycle got T+%0d want T+41", n);
    end
    rd(4'd10);
    n_chk++;
    if (q128 !== R10_128) begin
      n_fail++;
      $display("FAIL midrst_round10 got %h want %h", q128, R10_128);
    end
  endtask

  task automatic test_read_stream();
    logic [3:0]   rs [6];
    logic [127:0] ex [6];
    rs = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd15, 4'd1};
    ex = '{K128, R1_128, R2_128, R10_128, 128'h0, R1_128};
    rd_round = rs[0];
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 5) rd_round = rs[k+1];
      n_chk++;
      if (q128 !== ex[k]) begin
        n_fail++;
        $display("FAIL stream_%0d got %h want %h", k, q128, ex[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_ignore_start();
    test_reset_mid();
    test_read_stream();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
